mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter on the RV32I single-cycle core's data-store bus, in parallel with the data memory. Snoops every store cycle (MemWrite, Data_Adr, WriteData). Queues stores to one fixed address in a small FIFO and serialises them as 8N1 frames on a TX pin. The core cannot stall, so a store that arrives when the FIFO is full is dropped and counted.

---
 rtl/rv32i_mmio_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 56 +++++
 rtl/mmio_uart_tx.sv | 149 ++++++++++++++
 tb/tb_mmio_uart_tx.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_mmio_pkg.sv
// Shared types and constants for the memory-mapped peripherals on the RV32I
// data-store bus.
//   uart_state_t    : UART transmitter frame states
//   DEFAULT_TX_ADDR : store address that feeds the UART transmit FIFO
//   DATA_BITS       : data bits per UART frame
//   FRAME_BITS      : total bits per frame (start + data + stop)
package rv32i_mmio_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam logic [31:0] DEFAULT_TX_ADDR = 32'hFFFF_FFF0;
    localparam int          DATA_BITS       = 8;
    localparam int          FRAME_BITS      = 10;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO.
//   clk, reset : clock, asynchronous active-high reset (empties the FIFO)
//   push, din  : write request and data; honoured when not full, or when full
//                and a pop happens on the same edge
//   pop        : read request; ignored when empty
//   dout       : current head entry (valid whenever empty is low)
//   full/empty : status decoded from the registered pointers
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when the index
    // bits match, so every entry is usable across wrap-around.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    // NOTE: the storage array has no reset; entries are only read after being
    // written, and leaving it unreset lets it map onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter snooping the core's data-store bus.
//   clk, reset                    : clock, asynchronous active-high reset
//   MemWrite, Data_Adr, WriteData : store strobe, address and data; a store
//                                   to TX_ADDR enqueues WriteData[7:0]
//   tx        : serial output, idles high, registered
//   busy      : FIFO non-empty or a frame in progress
//   fifo_full : transmit FIFO holds FIFO_DEPTH bytes
//   ovf_cnt   : stores dropped because the FIFO was full, saturating at 255
module mmio_uart_tx
    import rv32i_mmio_pkg::*;
#(
    parameter int          CLK_DIV    = 434,
    parameter logic [31:0] TX_ADDR    = DEFAULT_TX_ADDR,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] Data_Adr,
    input  logic [31:0] WriteData,
    output logic        tx,
    output logic        busy,
    output logic        fifo_full,
    output logic [7:0]  ovf_cnt
);

    localparam int                 CNT_W    = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [2:0]         IDX_LAST = 3'(DATA_BITS - 1);

    uart_state_t          state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [2:0]           bit_idx, bit_idx_n;
    logic [7:0]           shift, shift_n;
    logic                 tx_n;
    logic                 bit_done;

    logic                 push_req;
    logic                 fifo_pop;
    logic                 fifo_empty;
    logic [7:0]           fifo_dout;
    logic                 drop;

    // Only the low byte of a store is transmitted.
    logic                 unused_wdata;
    assign unused_wdata = ^WriteData[31:8];

    assign push_req = MemWrite && (Data_Adr == TX_ADDR);
    // A pop on the same edge frees a slot, so a store to a full FIFO is kept.
    assign drop     = push_req && fifo_full && !fifo_pop;
    assign bit_done = (cnt == CNT_LAST);
    assign busy     = (state != IDLE) || !fifo_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .pop   (fifo_pop),
        .din   (WriteData[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_cnt <= 8'd0;
        end else if (drop && (ovf_cnt != 8'hFF)) begin
            ovf_cnt <= ovf_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
            tx      <= tx_n;
        end
    end

    // tx_n reflects the current state, so the line follows the FSM by one
    // cycle and is driven straight from a flop.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a variable
        // unassigned, which would otherwise infer a latch.
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        tx_n      = 1'b1;
        fifo_pop  = 1'b0;

        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_n  = fifo_dout;
                    cnt_n    = '0;
                    state_n  = START;
                end
            end
            START: begin
                tx_n = 1'b0;
                if (bit_done) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    state_n   = DATA;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                tx_n = shift[0];
                if (bit_done) begin
                    cnt_n   = '0;
                    shift_n = {1'b0, shift[7:1]};
                    if (bit_idx == IDX_LAST) begin
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_done) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx (CLK_DIV=4, FIFO_DEPTH=4).
// Stimulus pushes expected bytes into a scoreboard queue; a serial monitor
// decodes every frame on tx and compares it against the queue head.
module tb_mmio_uart_tx;

    localparam int          CLK_DIV    = 4;
    localparam int          FIFO_DEPTH = 4;
    localparam logic [31:0] TXA        = 32'hFFFF_FFF0;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        MemWrite  = 1'b0;
    logic [31:0] Data_Adr  = 32'h0;
    logic [31:0] WriteData = 32'h0;
    logic        tx;
    logic        busy;
    logic        fifo_full;
    logic [7:0]  ovf_cnt;

    int          n_checks   = 0;
    int          n_errors   = 0;
    int          cyc        = 0;
    int          rst_events = 0;
    logic        in_frame   = 1'b0;
    logic [7:0]  exp_q[$];
    int          starts[$];

    mmio_uart_tx #(
        .CLK_DIV    (CLK_DIV),
        .TX_ADDR    (TXA),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .Data_Adr  (Data_Adr),
        .WriteData (WriteData),
        .tx        (tx),
        .busy      (busy),
        .fifo_full (fifo_full),
        .ovf_cnt   (ovf_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge reset) rst_events <= rst_events + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive_store(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        MemWrite  = 1'b1;
        Data_Adr  = addr;
        WriteData = data;
    endtask

    task automatic idle_bus();
        @(negedge clk);
        MemWrite  = 1'b0;
        Data_Adr  = 32'h0;
        WriteData = 32'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        MemWrite = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        logic reached;
        reached = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (!busy && !in_frame) begin
                reached = 1'b1;
                break;
            end
        end
        check("idle_reached", {31'b0, reached}, 32'd1);
        repeat (3) @(negedge clk);
    endtask

    // Serial monitor: start detected at the first low sample, then each bit
    // is sampled one negedge into its cell and every 4 cycles after that.
    initial begin : monitor
        logic [7:0] rx;
        int         rst_snap;
        forever begin
            @(negedge clk);
            if (!reset && tx === 1'b0) begin
                in_frame = 1'b1;
                rst_snap = rst_events;
                starts.push_back(cyc);
                @(negedge clk);
                if (rst_events == rst_snap) check("start_bit", {31'b0, tx}, 32'd0);
                for (int b = 0; b < 8; b++) begin
                    repeat (CLK_DIV) @(negedge clk);
                    rx[b] = tx;
                end
                repeat (CLK_DIV) @(negedge clk);
                if (rst_events == rst_snap) begin
                    check("stop_bit", {31'b0, tx}, 32'd1);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_frame: got %02h expected none", rx);
                    end else begin
                        check("rx_byte", {24'b0, rx}, {24'b0, exp_q.pop_front()});
                    end
                end
                in_frame = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic saw_low;
        logic saw_busy;
        int   exp_ovf;
        logic [7:0] d;

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_tx", {31'b0, tx}, 32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_full", {31'b0, fifo_full}, 32'd0);
        check("rst_ovf", {24'b0, ovf_cnt}, 32'd0);
        reset = 1'b0;

        // Single byte: A5, start bit two edges after acceptance.
        drive_store(TXA, 32'h0000_00A5);
        exp_q.push_back(8'hA5);
        idle_bus();
        check("single_busy_after_accept", {31'b0, busy}, 32'd1);
        check("single_tx_idle_n0", {31'b0, tx}, 32'd1);
        @(negedge clk);
        check("single_tx_idle_n1", {31'b0, tx}, 32'd1);
        @(negedge clk);
        check("single_tx_start_n2", {31'b0, tx}, 32'd0);
        repeat (38) @(negedge clk);
        check("single_busy_n40", {31'b0, busy}, 32'd1);
        @(negedge clk);
        check("single_busy_n41", {31'b0, busy}, 32'd0);
        wait_idle(20);

        // Non-matching address, and matching address without MemWrite.
        drive_store(TXA + 32'd4, 32'h55);
        @(negedge clk);
        MemWrite  = 1'b0;
        Data_Adr  = TXA;
        WriteData = 32'h77;
        idle_bus();
        saw_low  = 1'b0;
        saw_busy = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (tx !== 1'b1) saw_low = 1'b1;
            if (busy !== 1'b0) saw_busy = 1'b1;
        end
        check("nomatch_tx_low", {31'b0, saw_low}, 32'd0);
        check("nomatch_busy", {31'b0, saw_busy}, 32'd0);
        check("nomatch_ovf", {24'b0, ovf_cnt}, 32'd0);

        // Overflow: six back-to-back stores, the sixth is dropped.
        do_reset();
        starts.delete();
        for (int i = 1; i <= 6; i++) begin
            drive_store(TXA, i);
            if (i <= 5) exp_q.push_back(8'(i));
            if (i == 5) check("ovf_full_before_5th", {31'b0, fifo_full}, 32'd0);
            if (i == 6) begin
                check("ovf_full_after_5th", {31'b0, fifo_full}, 32'd1);
                check("ovf_cnt_before_6th", {24'b0, ovf_cnt}, 32'd0);
            end
        end
        idle_bus();
        check("ovf_full_after_6th", {31'b0, fifo_full}, 32'd1);
        check("ovf_cnt_after_6th", {24'b0, ovf_cnt}, 32'd1);
        wait_idle(6 * 41 + 50);
        check("ovf_frame_count", starts.size(), 32'd5);
        for (int k = 1; k < starts.size(); k++)
            check("ovf_frame_spacing", starts[k] - starts[k-1], 32'd41);

        // Store exactly on the IDLE pop edge while the FIFO is full.
        do_reset();
        drive_store(TXA, 32'h11); exp_q.push_back(8'h11);
        drive_store(TXA, 32'h22); exp_q.push_back(8'h22);
        drive_store(TXA, 32'h33); exp_q.push_back(8'h33);
        drive_store(TXA, 32'h44); exp_q.push_back(8'h44);
        drive_store(TXA, 32'h55); exp_q.push_back(8'h55);
        repeat (37) idle_bus();
        check("simul_full_before_pop", {31'b0, fifo_full}, 32'd1);
        drive_store(TXA, 32'h66); exp_q.push_back(8'h66);
        idle_bus();
        check("simul_full_after_pop_push", {31'b0, fifo_full}, 32'd1);
        check("simul_ovf_unchanged", {24'b0, ovf_cnt}, 32'd0);
        wait_idle(7 * 41 + 50);

        // Saturation: stores on every edge; only pop edges accept.
        do_reset();
        exp_ovf = 0;
        for (int k = 0; k < 335; k++) begin
            d = 8'(k) ^ 8'h5A;
            drive_store(TXA, {24'b0, d});
            if (k == 200) check("sat_ovf_mid", {24'b0, ovf_cnt}, exp_ovf);
            if (k <= 4 || ((k - 1) % 41) == 0) exp_q.push_back(d);
            else if (exp_ovf < 255) exp_ovf++;
        end
        idle_bus();
        check("sat_ovf_final", {24'b0, ovf_cnt}, 32'hFF);
        check("sat_full", {31'b0, fifo_full}, 32'd1);
        wait_idle(9 * 41 + 50);
        check("sat_ovf_held", {24'b0, ovf_cnt}, 32'hFF);

        // Reset during DATA bit 3 of C3, with 3C still queued.
        do_reset();
        drive_store(TXA, 32'hC3);
        drive_store(TXA, 32'h3C);
        idle_bus();
        repeat (17) @(negedge clk);
        check("rstmid_tx_low_before", {31'b0, tx}, 32'd0);
        reset = 1'b1;
        #1;
        check("rstmid_tx_async", {31'b0, tx}, 32'd1);
        check("rstmid_busy_async", {31'b0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rstmid_busy_after", {31'b0, busy}, 32'd0);
        check("rstmid_ovf_after", {24'b0, ovf_cnt}, 32'd0);
        saw_low  = 1'b0;
        saw_busy = 1'b0;
        repeat (120) begin
            @(negedge clk);
            if (tx !== 1'b1) saw_low = 1'b1;
            if (busy !== 1'b0) saw_busy = 1'b1;
        end
        check("rstmid_no_frame", {31'b0, saw_low}, 32'd0);
        check("rstmid_no_busy", {31'b0, saw_busy}, 32'd0);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
